led_sequencer: RTL and testbench

- Hardware LED pattern sequencer for the Nios system.
- Configured by the CPU through a 4-word Avalon-MM slave.
- Autonomously drives the LED PIO's s1 slave (8-bit data register at address 0) through a write-only Avalon-MM master.
- Steps an 8-bit pattern every PERIOD clocks with rotate-left, rotate-right or bounce motion, offloading LED animation from software.

---
 rtl/led_seq_pkg.sv | 31 +++
 rtl/led_seq_tick.sv | 30 +++
 rtl/led_sequencer.sv | 169 ++++++++++++++++
 tb/tb_led_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_PERIOD  = 2'd1;
    localparam logic [1:0] ADDR_PATTERN = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_DIR    = 1;
    localparam int CTRL_BOUNCE = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_IRQ_PEND = 1;

    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

    // PERIOD of 0 behaves as 1, so the last tick index never underflows.
    function automatic logic [31:0] terminal_of(input logic [31:0] period);
        return (period == 32'd0) ? 32'd0 : period - 32'd1;
    endfunction

endpackage

// File: rtl/led_seq_tick.sv
// Step-interval counter: counts up from a clear and flags when the last tick
// of the current PERIOD has been reached.
module led_seq_tick
    import led_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic [31:0] i_period,
    output logic        o_terminal
);

    logic [31:0] r_count;
    logic [31:0] w_last;

    assign w_last = terminal_of(i_period);
    // ">=" so that shrinking PERIOD below the current count fires immediately.
    assign o_terminal = (r_count >= w_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 32'd0;
        end else if (i_clear) begin
            r_count <= 32'd0;
        end else begin
            r_count <= r_count + 32'd1;
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: CPU-programmed Avalon-MM slave that drives the LED PIO.
// Optional LEDSEQ_IRQ_EN adds a level irq raised when STEP wraps.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PERIOD_RST = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [1:0]  pio_address,
    output logic [31:0] pio_writedata
`ifdef LEDSEQ_IRQ_EN
    ,
    output logic        irq
`endif
);

    state_t              r_state;
    state_t              w_state_next;
    logic [3:0]          r_ctrl;
    logic [31:0]         r_period;
    logic [DATA_W-1:0]   r_pattern;
    logic [7:0]          r_step;
    logic                r_pio_cs;
    logic [DATA_W-1:0]   r_pio_data;

    logic                w_wr;
    logic                w_terminal;
    logic                w_fire;
    logic                w_turn;
    logic                w_move_right;
    logic                w_irq_pend;
    logic                w_ctrl_irq_bit;
    logic [DATA_W-1:0]   w_rol;
    logic [DATA_W-1:0]   w_ror;
    logic [DATA_W-1:0]   w_next_pat;

    assign w_wr = chipselect & ~write_n;

    led_seq_tick u_tick (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_state_next != COUNT),
        .i_period   (r_period),
        .o_terminal (w_terminal)
    );

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_rot
            assign w_rol[gi] = r_pattern[(gi + DATA_W - 1) % DATA_W];
            assign w_ror[gi] = r_pattern[(gi + 1) % DATA_W];
        end
    endgenerate

    // Bounce turns around at the edge being approached instead of wrapping.
    assign w_turn = r_ctrl[CTRL_BOUNCE] &
                    (r_ctrl[CTRL_DIR] ? r_pattern[0] : r_pattern[DATA_W-1]);
    assign w_move_right = r_ctrl[CTRL_DIR] ^ w_turn;
    assign w_next_pat   = w_move_right ? w_ror : w_rol;

    always_comb begin
        w_state_next = r_state;
        w_fire       = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_ctrl[CTRL_EN]) begin
                    w_state_next = LOAD;
                end
            end
            default: begin
                if (!r_ctrl[CTRL_EN]) begin
                    w_state_next = IDLE;
                end else if (w_terminal) begin
                    w_fire       = 1'b1;
                    w_state_next = WRITE;
                end else begin
                    w_state_next = COUNT;
                end
            end
        endcase
    end

`ifdef LEDSEQ_IRQ_EN
    logic r_irq_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_pend <= 1'b0;
        end else if (w_fire && (r_step == 8'hFF)) begin
            r_irq_pend <= 1'b1;
        end else if (w_wr && (address == ADDR_STATUS) && writedata[STAT_IRQ_PEND]) begin
            r_irq_pend <= 1'b0;
        end
    end

    assign w_irq_pend     = r_irq_pend;
    assign w_ctrl_irq_bit = writedata[CTRL_IRQ_EN];
    assign irq            = r_irq_pend & r_ctrl[CTRL_IRQ_EN];
`else
    assign w_irq_pend     = 1'b0;
    assign w_ctrl_irq_bit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ctrl     <= 4'd0;
            r_period   <= 32'(PERIOD_RST);
            r_pattern  <= DATA_W'(1);
            r_step     <= 8'd0;
            r_pio_cs   <= 1'b0;
            r_pio_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_fire) begin
                r_pattern <= w_next_pat;
                r_step    <= r_step + 8'd1;
                if (w_turn) begin
                    r_ctrl[CTRL_DIR] <= ~r_ctrl[CTRL_DIR];
                end
            end
            // CPU writes are applied last so they win over a same-cycle step.
            if (w_wr && (address == ADDR_CTRL)) begin
                r_ctrl <= {w_ctrl_irq_bit, writedata[2:0]};
            end
            if (w_wr && (address == ADDR_PERIOD)) begin
                r_period <= writedata;
            end
            if (w_wr && (address == ADDR_PATTERN)) begin
                r_pattern <= writedata[DATA_W-1:0];
            end
            r_pio_cs <= (w_state_next == LOAD) | w_fire;
            if (w_state_next == LOAD) begin
                r_pio_data <= r_pattern;
            end else if (w_fire) begin
                r_pio_data <= w_next_pat;
            end
        end
    end

    assign pio_chipselect = r_pio_cs;
    assign pio_write_n    = ~r_pio_cs;
    assign pio_address    = PIO_DATA_ADDR;
    assign pio_writedata  = {{(32-DATA_W){1'b0}}, r_pio_data};

    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_CTRL:    readdata[3:0]        = r_ctrl;
            ADDR_PERIOD:  readdata             = r_period;
            ADDR_PATTERN: readdata[DATA_W-1:0] = r_pattern;
            default: begin
                readdata[STAT_BUSY]     = (r_state != IDLE);
                readdata[STAT_IRQ_PEND] = w_irq_pend;
                readdata[15:8]          = r_step;
            end
        endcase
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer: expected PIO writes (value, cycle) are
// queued by the stimulus and checked by an independent monitor.
module tb_led_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [1:0]  pio_address;
    logic [31:0] pio_writedata;
`ifdef LEDSEQ_IRQ_EN
    logic        irq;
`endif

    led_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .address        (address),
        .chipselect     (chipselect),
        .write_n        (write_n),
        .writedata      (writedata),
        .readdata       (readdata),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_address    (pio_address),
        .pio_writedata  (pio_writedata)
`ifdef LEDSEQ_IRQ_EN
        ,
        .irq            (irq)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Monitor: every PIO write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (pio_chipselect && !pio_write_n) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL pio_unexpected: got write 0x%08h at cycle %0d, required no write",
                         pio_writedata, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                if (pio_writedata !== {24'd0, mon_e.data} || cyc != mon_e.at || pio_address !== 2'd0) begin
                    n_bad++;
                    $display("FAIL pio_write: got 0x%08h @cycle %0d addr %0d, required 0x%02h @cycle %0d addr 0",
                             pio_writedata, cyc, pio_address, mon_e.data, mon_e.at);
                end else begin
                    $display("pio write 0x%02h at cycle %0d ok", mon_e.data, cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
        end else begin
            $display("check %s = 0x%08h ok", name, got);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, output int k);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        k          = cyc;
        $display("cpu write addr %0d data 0x%08h at cycle %0d", a, d, k);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
    endtask

    task automatic reg_read(input logic [1:0] a, input logic [31:0] exp, input string name);
        address = a;
        #1;
        check(name, readdata, exp);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d, input int at);
        exp_t e;
        e.data = d;
        e.at   = at;
        sb_q.push_back(e);
    endtask

    initial begin
        int k;
        int kd;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_pio_cs", {31'd0, pio_chipselect}, 32'd0);
        check("rst_pio_wn", {31'd0, pio_write_n}, 32'd1);
        check("rst_pio_data", pio_writedata, 32'd0);
        reg_read(2'd0, 32'd0, "rst_ctrl");
        reg_read(2'd1, 32'd50000000, "rst_period");
        reg_read(2'd2, 32'h01, "rst_pattern");
        reg_read(2'd3, 32'd0, "rst_status");

        // Rotate left, PERIOD=4
        bus_write(2'd1, 32'd4, kd);
        bus_write(2'd2, 32'h01, kd);
        bus_write(2'd0, 32'h1, k);
        push(8'h01, k + 2);
        push(8'h02, k + 6);
        push(8'h04, k + 10);
        push(8'h08, k + 14);
        wait_cyc(k + 15);
        reg_read(2'd3, 32'h0301, "left_status_step3");
        bus_write(2'd0, 32'h0, kd);
        wait_cyc(k + 30);
        check("left_drained", 32'(sb_q.size()), 32'd0);

        // Rotate right wraps bit0 to bit7
        bus_write(2'd2, 32'h01, kd);
        bus_write(2'd0, 32'h3, k);
        push(8'h01, k + 2);
        push(8'h80, k + 6);
        push(8'h40, k + 10);
        wait_cyc(k + 11);
        bus_write(2'd0, 32'h0, kd);
        wait_cyc(k + 30);
        reg_read(2'd3, 32'h0500, "right_status");
        check("right_drained", 32'(sb_q.size()), 32'd0);

        // Bounce at bit7, PERIOD=2
        bus_write(2'd1, 32'd2, kd);
        bus_write(2'd2, 32'h40, kd);
        bus_write(2'd0, 32'h5, k);
        push(8'h40, k + 2);
        push(8'h80, k + 4);
        push(8'h40, k + 6);
        wait_cyc(k + 6);
        reg_read(2'd0, 32'h7, "bounce_ctrl_dir");
        bus_write(2'd0, 32'h0, kd);
        wait_cyc(k + 20);
        check("bounce_drained", 32'(sb_q.size()), 32'd0);

        // Clear EN while counting: silence for 10 periods, LEDs hold
        bus_write(2'd1, 32'd4, kd);
        bus_write(2'd2, 32'h11, kd);
        bus_write(2'd0, 32'h1, k);
        push(8'h11, k + 2);
        push(8'h22, k + 6);
        wait_cyc(k + 8);
        bus_write(2'd0, 32'h0, kd);
        wait_cyc(k + 9 + 40);
        reg_read(2'd3, 32'h0800, "stop_status_idle");
        check("stop_led_hold", pio_writedata, 32'h22);
        check("stop_drained", 32'(sb_q.size()), 32'd0);

        // PERIOD=0 steps every cycle
        bus_write(2'd1, 32'd0, kd);
        bus_write(2'd2, 32'h01, kd);
        bus_write(2'd0, 32'h1, k);
        push(8'h01, k + 2);
        push(8'h02, k + 3);
        push(8'h04, k + 4);
        push(8'h08, k + 5);
        wait_cyc(k + 4);
        bus_write(2'd0, 32'h0, kd);
        wait_cyc(k + 20);
        reg_read(2'd3, 32'h0B00, "p0_status");
        check("p0_drained", 32'(sb_q.size()), 32'd0);

        // Reset during a WRITE cycle
        bus_write(2'd1, 32'd4, kd);
        bus_write(2'd2, 32'h03, kd);
        bus_write(2'd0, 32'h1, k);
        push(8'h03, k + 2);
        push(8'h06, k + 6);
        wait_cyc(k + 6);
        reset = 1'b1;
        @(negedge clk);
        check("rstw_pio_cs", {31'd0, pio_chipselect}, 32'd0);
        check("rstw_pio_wn", {31'd0, pio_write_n}, 32'd1);
        reg_read(2'd0, 32'd0, "rstw_ctrl");
        reg_read(2'd2, 32'h01, "rstw_pattern");
        reg_read(2'd3, 32'd0, "rstw_status");
        reg_read(2'd1, 32'd50000000, "rstw_period");
        reset = 1'b0;
        @(negedge clk);
        check("rstw_drained", 32'(sb_q.size()), 32'd0);

`ifdef LEDSEQ_IRQ_EN
        // STEP wrap raises irq; STATUS bit1 write clears it
        bus_write(2'd1, 32'd1, kd);
        bus_write(2'd0, 32'h9, k);
        for (int i = 0; i <= 257; i++) begin
            push(8'(1 << (i % 8)), k + 2 + i);
        end
        wait_cyc(k + 257);
        check("irq_before_wrap", {31'd0, irq}, 32'd0);
        wait_cyc(k + 258);
        check("irq_after_wrap", {31'd0, irq}, 32'd1);
        reg_read(2'd3, 32'h0003, "irq_status_pend");
        bus_write(2'd0, 32'h8, kd);
        check("irq_held", {31'd0, irq}, 32'd1);
        bus_write(2'd3, 32'h2, kd);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        wait_cyc(k + 280);
        check("irq_drained", 32'(sb_q.size()), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
